cache_path_scheduler: RTL and testbench

//   Synchronous scheduler in front of the two-way conditional-fork cache selector.

---
 rtl/cache_path_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_cache_path_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_path_scheduler.sv
// cache_path_scheduler
// Round-robin front end for the two-way conditional-fork cache selector.
// A winning requester gets a one-cycle grant. Its path select is registered and held
// while the transaction runs. The selector is launched with a two-phase drive toggle.
// The owner gets a one-cycle done pulse once both the upstream ack (i_free) and the
// downstream completion (i_done) toggles have been seen.
module cache_path_scheduler #(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_path,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic             o_drive,
  output logic             o_valid0,
  output logic             o_valid1,
  input  logic             i_free,
  input  logic             i_done,
  output logic [1:0]       err
);

  localparam int              PTR_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SETUP,
    S_WAIT,
    S_DONE,
    S_HALT
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic                   valid0_q, valid0_d;
  logic                   valid1_q, valid1_d;
  logic                   drive_q, drive_d;
  logic                   seen_free_q, seen_free_d;
  logic                   seen_done_q, seen_done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             err_q, err_d;
  logic [SYNC_STAGES-1:0] free_sync_q, free_sync_d;
  logic [SYNC_STAGES-1:0] done_sync_q, done_sync_d;
  logic                   free_last_q, free_last_d;
  logic                   done_last_q, done_last_d;

  logic                   ev_free;
  logic                   ev_done;
  logic                   ev_any;
  logic                   found;
  logic [PTR_W-1:0]       winner;
  logic [PTR_W-1:0]       cand;
  int                     idx;

  // Synchronizer shift chains and last-seen phase.
  // A change of phase on the chain output is an event.
  always_comb begin
    free_sync_d = {free_sync_q[SYNC_STAGES-2:0], i_free};
    done_sync_d = {done_sync_q[SYNC_STAGES-2:0], i_done};
    free_last_d = free_sync_q[SYNC_STAGES-1];
    done_last_d = done_sync_q[SYNC_STAGES-1];
  end

  assign ev_free = free_sync_q[SYNC_STAGES-1] ^ free_last_q;
  assign ev_done = done_sync_q[SYNC_STAGES-1] ^ done_last_q;
  assign ev_any  = ev_free | ev_done;

  // Round-robin pick: first active request at or after ptr, wrapping past N_REQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Transaction sequencing.
  // Any selector event outside WAIT, or a repeated one inside WAIT, is a protocol error.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    valid0_d    = valid0_q;
    valid1_d    = valid1_q;
    drive_d     = drive_q;
    seen_free_d = seen_free_q;
    seen_done_d = seen_done_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (ev_any) begin
          err_d[1] = 1'b1;
          state_d  = S_HALT;
        end else if (found) begin
          owner_d = winner;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (ev_any) begin
          err_d[1] = 1'b1;
          state_d  = S_HALT;
        end else begin
          valid0_d = ~req_path[owner_q];
          valid1_d = req_path[owner_q];
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (ev_any) begin
          err_d[1] = 1'b1;
          state_d  = S_HALT;
        end else begin
          drive_d     = ~drive_q;
          cnt_d       = '0;
          seen_free_d = 1'b0;
          seen_done_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d       = cnt_q + 1'b1;
        seen_free_d = seen_free_q | ev_free;
        seen_done_d = seen_done_q | ev_done;
        if ((ev_free && seen_free_q) || (ev_done && seen_done_q)) begin
          err_d[1] = 1'b1;
          state_d  = S_HALT;
        end else if (seen_free_d && seen_done_d) begin
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_d == TIMEOUT_CNT)) begin
          err_d[0] = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_DONE: begin
        if (ev_any) begin
          err_d[1] = 1'b1;
          state_d  = S_HALT;
        end else begin
          valid0_d = 1'b0;
          valid1_d = 1'b0;
          ptr_d    = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // State and datapath registers; an asynchronous reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      drive_q     <= 1'b0;
      seen_free_q <= 1'b0;
      seen_done_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 2'b00;
      free_sync_q <= '0;
      done_sync_q <= '0;
      free_last_q <= 1'b0;
      done_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      valid0_q    <= valid0_d;
      valid1_q    <= valid1_d;
      drive_q     <= drive_d;
      seen_free_q <= seen_free_d;
      seen_done_q <= seen_done_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      free_sync_q <= free_sync_d;
      done_sync_q <= done_sync_d;
      free_last_q <= free_last_d;
      done_last_q <= done_last_d;
    end
  end

  // Grant and done pulses are decoded from the registered state and owner.
  always_comb begin
    grant = '0;
    done  = '0;
    if (state_q == S_GRANT) grant[owner_q] = 1'b1;
    if (state_q == S_DONE)  done[owner_q]  = 1'b1;
  end

  assign busy     = (state_q != S_IDLE);
  assign o_drive  = drive_q;
  assign o_valid0 = valid0_q;
  assign o_valid1 = valid1_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cache_path_scheduler.sv
// tb_cache_path_scheduler
// Directed scenarios driving the scheduler.
// A transaction-level reference model is compared against the DUT outputs on every
// cycle, alongside literal expectations at key points of each scenario.
`timescale 1ns/1ps
module tb_cache_path_scheduler;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int TO = 10;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_path = '0;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         busy;
  logic         o_drive;
  logic         o_valid0;
  logic         o_valid1;
  logic         i_free = 1'b0;
  logic         i_done = 1'b0;
  logic [1:0]   err;

  int  checks = 0;
  int  failures = 0;
  int  drive_toggles = 0;
  int  done_pulses = 0;
  bit  cmp_en = 1'b0;
  logic last_drive = 1'b0;

  cache_path_scheduler #(
    .N_REQ(N), .SYNC_STAGES(S), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_path(req_path),
    .grant(grant), .done(done), .busy(busy), .o_drive(o_drive),
    .o_valid0(o_valid0), .o_valid1(o_valid1),
    .i_free(i_free), .i_done(i_done), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  bit hf [0:S];
  bit hd [0:S];
  int m_ptr = 0, m_owner = 0, m_age = 0, m_wait = 0;
  bit m_active = 0, m_in_done = 0, m_halt = 0, m_path = 0;
  bit m_seen_f = 0, m_seen_d = 0, m_drive = 0, m_v0 = 0, m_v1 = 0;
  bit [1:0] m_err = 2'b00;

  task automatic m_halt_with(input bit [1:0] code);
    m_halt    = 1'b1;
    m_err     = m_err | code;
    m_active  = 1'b0;
    m_in_done = 1'b0;
  endtask

  task automatic model_step();
    bit evf, evd, ev, dup, got;
    if (rst) begin
      for (int k = 0; k <= S; k++) begin hf[k] = 1'b0; hd[k] = 1'b0; end
      m_ptr = 0; m_owner = 0; m_age = 0; m_wait = 0;
      m_active = 0; m_in_done = 0; m_halt = 0; m_path = 0;
      m_seen_f = 0; m_seen_d = 0; m_drive = 0; m_v0 = 0; m_v1 = 0; m_err = 2'b00;
      return;
    end
    // an input phase change is visible as an event S cycles after it is sampled
    evf = hf[S-1] ^ hf[S];
    evd = hd[S-1] ^ hd[S];
    ev  = evf | evd;
    for (int k = S; k > 0; k--) begin hf[k] = hf[k-1]; hd[k] = hd[k-1]; end
    hf[0] = i_free;
    hd[0] = i_done;
    if (m_halt) return;
    if (m_in_done) begin
      if (ev) m_halt_with(2'b10);
      else begin
        m_v0 = 1'b0; m_v1 = 1'b0;
        m_ptr = (m_owner + 1) % N;
        m_in_done = 1'b0;
      end
    end else if (m_active) begin
      if (m_age == 0) begin
        if (ev) m_halt_with(2'b10);
        else begin
          m_path = req_path[m_owner];
          m_v0 = !m_path; m_v1 = m_path;
          m_age = 1;
        end
      end else if (m_age == 1) begin
        if (ev) m_halt_with(2'b10);
        else begin
          m_drive = !m_drive;
          m_seen_f = 0; m_seen_d = 0; m_wait = 0;
          m_age = 2;
        end
      end else begin
        dup = (evf && m_seen_f) || (evd && m_seen_d);
        m_seen_f = m_seen_f | evf;
        m_seen_d = m_seen_d | evd;
        m_wait++;
        if (dup) m_halt_with(2'b10);
        else if (m_seen_f && m_seen_d) begin m_active = 1'b0; m_in_done = 1'b1; end
        else if (m_wait == TO) m_halt_with(2'b01);
      end
    end else begin
      if (ev) m_halt_with(2'b10);
      else if (req != '0) begin
        got = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!got && req[(m_ptr + i) % N]) begin got = 1'b1; m_owner = (m_ptr + i) % N; end
        end
        m_active = 1'b1;
        m_age = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  function automatic logic [N-1:0] exp_grant();
    return (m_active && m_age == 0) ? N'(1 << m_owner) : '0;
  endfunction

  function automatic logic [N-1:0] exp_done();
    return m_in_done ? N'(1 << m_owner) : '0;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, plus a one-line log per finished txn
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("grant",  32'(grant),    32'(exp_grant()));
      chk("done",   32'(done),     32'(exp_done()));
      chk("busy",   32'(busy),     32'(m_active | m_in_done | m_halt));
      chk("drive",  32'(o_drive),  32'(m_drive));
      chk("valid0", 32'(o_valid0), 32'(m_v0));
      chk("valid1", 32'(o_valid1), 32'(m_v1));
      chk("err",    32'(err),      32'(m_err));
      if (o_drive !== last_drive) drive_toggles++;
      if (done != '0) begin
        done_pulses++;
        $display("txn done mask=%b valids=%b%b err=%b t=%0t", done, o_valid1, o_valid0, err, $time);
      end
    end
    last_drive <= o_drive;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_path = '0; i_free = 1'b0; i_done = 1'b0;
    #1;
    chk("rst_outputs_zero", 32'({grant, done, busy, o_drive, o_valid0, o_valid1, err}), 32'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int gidx);
    int n = 0;
    while (grant == '0 && n < 40) begin step(); n++; end
    chk("grant_seen", 32'(grant != '0), 32'd1);
    gidx = -1;
    for (int i = 0; i < N; i++) if (grant[i]) gidx = i;
  endtask

  task automatic wait_drive(input logic prev);
    int n = 0;
    while (o_drive == prev && n < 40) begin step(); n++; end
    chk("drive_seen", 32'(o_drive != prev), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done == '0 && n < 40) begin step(); n++; end
    chk("done_seen", 32'(done != '0), 32'd1);
  endtask

  task automatic wait_err(output int cyc);
    cyc = 0;
    while (err == 2'b00 && cyc < 30) begin step(); cyc++; end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int   gidx, n;
    logic pd;
    int   rr_exp [5] = '{0, 1, 2, 3, 0};

    #2;
    cmp_en = 1'b1;
    do_reset();

    // single transaction on path 1
    req = 4'b0001; req_path = 4'b0001;
    step();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_valid1_in_grant", 32'(o_valid1), 32'd0);
    req = '0;
    step();
    chk("t1_setup_valids", 32'({o_valid1, o_valid0}), 32'h2);
    chk("t1_drive_before", 32'(o_drive), 32'd0);
    step();
    chk("t1_drive_after", 32'(o_drive), 32'd1);
    i_free = 1'b1;
    step(); step(); step();
    i_done = 1'b1;
    step(); step();
    chk("t1_no_done_yet", 32'(done), 32'd0);
    step();
    chk("t1_done", 32'(done), 32'h1);
    step();
    chk("t1_idle", 32'({busy, o_valid0, o_valid1, done}), 32'd0);

    // round robin with all requesters held
    do_reset();
    drive_toggles = 0;
    req = 4'b1111; req_path = 4'b1010;
    for (int t = 0; t < 5; t++) begin
      wait_grant(gidx);
      chk("t2_order", 32'(gidx), 32'(rr_exp[t]));
      if (t == 4) req = '0;
      pd = o_drive;
      wait_drive(pd);
      step(); step(); step();
      i_free = ~i_free;
      step();
      i_done = ~i_done;
      wait_done();
    end
    step(); step();
    chk("t2_drive_toggles", 32'(drive_toggles), 32'd5);

    // simultaneous free and done
    req = 4'b0100; req_path = 4'b0000;
    wait_grant(gidx);
    chk("t3_owner", 32'(gidx), 32'd2);
    req = '0;
    done_pulses = 0;
    pd = o_drive;
    wait_drive(pd);
    step(); step(); step();
    i_free = ~i_free; i_done = ~i_done;
    wait_done();
    repeat (4) step();
    chk("t3_done_once", 32'(done_pulses), 32'd1);
    chk("t3_no_err", 32'(err), 32'd0);

    // timeout with no response
    req = 4'b0010; req_path = 4'b0010;
    wait_grant(gidx);
    req = '0;
    pd = o_drive;
    wait_drive(pd);
    wait_err(n);
    chk("t4_err_timeout", 32'(err), 32'h1);
    chk("t4_wait_cycles", 32'(n), 32'd10);
    req = 4'b1111;
    repeat (8) begin
      step();
      chk("t4_no_grant_halt", 32'(grant), 32'd0);
    end
    chk("t4_busy_halt", 32'(busy), 32'd1);

    // protocol: toggle while idle
    do_reset();
    step(); step();
    i_free = 1'b1;
    wait_err(n);
    chk("t5a_err_protocol", 32'(err), 32'h2);
    chk("t5a_busy", 32'(busy), 32'd1);

    // protocol: double free toggle in wait
    do_reset();
    req = 4'b0001; req_path = 4'b0000;
    wait_grant(gidx);
    req = '0;
    pd = o_drive;
    wait_drive(pd);
    i_free = ~i_free;
    step();
    i_free = ~i_free;
    wait_err(n);
    chk("t5b_err_protocol", 32'(err), 32'h2);

    // reset in the middle of WAIT
    do_reset();
    req = 4'b1000; req_path = 4'b1000;
    wait_grant(gidx);
    chk("t6_owner", 32'(gidx), 32'd3);
    req = '0;
    pd = o_drive;
    wait_drive(pd);
    i_free = 1'b1;
    step();
    done_pulses = 0;
    do_reset();
    chk("t6_no_done", 32'(done_pulses), 32'd0);
    req = 4'b1010; req_path = 4'b0000;
    wait_grant(gidx);
    chk("t6_grant_after_reset", 32'(grant), 32'h2);
    req = '0;
    pd = o_drive;
    wait_drive(pd);
    i_free = ~i_free; i_done = ~i_done;
    wait_done();
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global guard so a stuck run still ends
  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
